// File: rtl/act_dma_pkg.sv
// Shared definitions for the activation-vector DMA: CSR offsets, FSM states
// and the Q16.16 helpers used by the write drainer.
package act_dma_pkg;

  localparam logic [3:0] REG_START = 4'd0;
  localparam logic [3:0] REG_SRC   = 4'd1;
  localparam logic [3:0] REG_DST   = 4'd2;
  localparam logic [3:0] REG_COUNT = 4'd3;
  localparam logic [3:0] REG_CTRL  = 4'd4;

  // Sign bit of a Q16.16 word; set means the activation is negative.
  localparam logic [31:0] Q16_SIGN_BIT = 32'h8000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ReLU on a Q16.16 word: negative values become zero when enabled.
  function automatic logic [31:0] relu_clamp(input logic [31:0] word, input logic en);
    return (en && ((word & Q16_SIGN_BIT) != 32'd0)) ? 32'd0 : word;
  endfunction

endpackage

// File: rtl/act_dma_sync_fifo.sv
// Small synchronous FIFO decoupling the SDRAM read stream from the SRAM
// write stream. The head word is read straight from storage, so a word
// pushed into an empty FIFO becomes visible one cycle later.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/act_dma.sv
// Activation DMA: copies N Q16.16 words from SDRAM to the accelerator's SRAM
// bank with optional in-flight ReLU. Reads are only issued when a FIFO slot
// is reserved for the returning data, so the FIFO can never overflow.
module act_dma
  import act_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic        master2_waitrequest,
  output logic [31:0] master2_address,
  output logic        master2_read,
  input  logic [31:0] master2_readdata,
  input  logic        master2_readdatavalid,
  output logic        master2_write,
  output logic [31:0] master2_writedata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] DEPTH32 = 32'(FIFO_DEPTH);

  state_t      state_q, state_d;
  logic        busy;
  logic        launch;
  logic [31:0] src_reg, dst_reg, count_reg;
  logic        relu_reg;
  logic [31:0] src_q, dst_q, len_q;
  logic        relu_q;
  logic [31:0] issued_q, received_q, written_q;
  logic [31:0] reserved;
  logic        push, pop;
  logic [31:0] fifo_head;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        unused_inputs;

  assign unused_inputs = ^{master2_readdata, master2_readdatavalid};

  assign busy   = (state_q == RUN);
  assign launch = slave_write && (slave_address == REG_START) && !busy && (count_reg != 32'd0);

  assign slave_waitrequest = slave_read && (slave_address == REG_START) && busy;

  // Reads issued but not yet returned, plus words already buffered.
  assign reserved = issued_q - received_q + 32'(fifo_count);

  // Only accept read data that this job is still waiting for; stale pulses
  // arriving after a reset find nothing outstanding and are dropped.
  assign push = master_readdatavalid && busy && (received_q != issued_q);
  assign pop  = master2_write && !master2_waitrequest;

  assign master_address    = src_q + {issued_q[29:0], 2'b00};
  assign master2_address   = dst_q + {written_q[29:0], 2'b00};
  assign master2_writedata = master2_write ? relu_clamp(fifo_head, relu_q) : 32'd0;
  assign master_write      = 1'b0;
  assign master_writedata  = 32'd0;
  assign master2_read      = 1'b0;

  // CSR read mux; offset 0 and unmapped offsets read as zero.
  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        REG_SRC:   slave_readdata = src_reg;
        REG_DST:   slave_readdata = dst_reg;
        REG_COUNT: slave_readdata = count_reg;
        REG_CTRL:  slave_readdata = {31'd0, relu_reg};
        default:   slave_readdata = 32'd0;
      endcase
    end
  end

  // Programmable CSRs, writable at any time; the running job uses its own copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg   <= 32'd0;
      dst_reg   <= 32'd0;
      count_reg <= 32'd0;
      relu_reg  <= 1'b0;
    end else if (slave_write) begin
      case (slave_address)
        REG_SRC:   src_reg   <= slave_writedata;
        REG_DST:   dst_reg   <= slave_writedata;
        REG_COUNT: count_reg <= slave_writedata;
        REG_CTRL:  relu_reg  <= slave_writedata[0];
        default:   ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and bus strobes; both strobes are functions of registered
  // state only, so they stay put while the slave stalls.
  always_comb begin
    state_d       = state_q;
    master_read   = 1'b0;
    master2_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = RUN;
        end
      end
      RUN: begin
        master_read   = (issued_q != len_q) && (reserved < DEPTH32);
        master2_write = !fifo_empty;
        if (master2_write && !master2_waitrequest && (written_q == len_q - 32'd1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Working copies latched at launch and the per-job progress counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      len_q      <= 32'd0;
      relu_q     <= 1'b0;
      issued_q   <= 32'd0;
      received_q <= 32'd0;
      written_q  <= 32'd0;
    end else if (launch) begin
      src_q      <= src_reg;
      dst_q      <= dst_reg;
      len_q      <= count_reg;
      relu_q     <= relu_reg;
      issued_q   <= 32'd0;
      received_q <= 32'd0;
      written_q  <= 32'd0;
    end else begin
      if (master_read && !master_waitrequest) begin
        issued_q <= issued_q + 32'd1;
      end
      if (push) begin
        received_q <= received_q + 32'd1;
      end
      if (pop) begin
        written_q <= written_q + 32'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(master_readdata),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The read reservation must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_act_dma.sv
// Testbench for act_dma: SDRAM/SRAM bus models with random stalls and
// latency, a job-level reference model feeding expectation queues, and a
// monitor that checks every accepted bus transfer against those queues.
module tb_act_dma;

  localparam int DEPTH = 8;
  localparam logic [3:0] OFF_START = 4'd0;
  localparam logic [3:0] OFF_SRC   = 4'd1;
  localparam logic [3:0] OFF_DST   = 4'd2;
  localparam logic [3:0] OFF_COUNT = 4'd3;
  localparam logic [3:0] OFF_CTRL  = 4'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = 4'd0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'd0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = 32'd0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master2_waitrequest = 1'b0;
  logic [31:0] master2_address;
  logic        master2_read;
  logic [31:0] master2_readdata = 32'd0;
  logic        master2_readdatavalid = 1'b0;
  logic        master2_write;
  logic [31:0] master2_writedata;

  always #5 clk = ~clk;

  act_dma #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master2_waitrequest  (master2_waitrequest),
    .master2_address      (master2_address),
    .master2_read         (master2_read),
    .master2_readdata     (master2_readdata),
    .master2_readdatavalid(master2_readdatavalid),
    .master2_write        (master2_write),
    .master2_writedata    (master2_writedata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  resp_t       resp_q[$];
  logic [31:0] sdram_mem [logic [31:0]];
  logic [31:0] sram_mem  [logic [31:0]];
  int          stall_pct = 0;
  int          lat_min = 3;
  int          lat_max = 3;
  int          cycle = 0;
  int          last_due = 0;
  int          job_rd = 0;
  int          job_wr = 0;
  int          strobe_cycles = 0;

  // Single comparison point; every check in the bench goes through here.
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // SDRAM contents: explicit entries where a test needs them, otherwise a hash.
  function automatic logic [31:0] sdram_read(input logic [31:0] a);
    if (sdram_mem.exists(a)) return sdram_mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Bus responder: random stalls and in-order SDRAM read data after a random latency.
  always @(negedge clk) begin
    int due;
    cycle = cycle + 1;
    master_waitrequest  = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
    master2_waitrequest = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
    if (resp_q.size() > 0 && resp_q[0].due <= cycle) begin
      master_readdatavalid = 1'b1;
      master_readdata      = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata      = $urandom;
    end
    if (rst_n && master_read && !master_waitrequest) begin
      due = cycle + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      resp_q.push_back('{due, sdram_read(master_address)});
    end
  end

  // Monitor: checks every accepted transfer and the hold rules while stalled.
  logic        prev_rd_stall = 1'b0;
  logic        prev_wr_stall = 1'b0;
  logic [31:0] prev_rd_addr = 32'd0;
  logic [31:0] prev_wr_addr = 32'd0;
  logic [31:0] prev_wr_data = 32'd0;
  always @(negedge clk) begin
    wr_t e;
    #1;
    if (!rst_n) begin
      prev_rd_stall = 1'b0;
      prev_wr_stall = 1'b0;
    end else begin
      if (master_read || master2_write) strobe_cycles++;
      if (prev_rd_stall) begin
        check_output("rd_hold_strobe", 32'(master_read), 32'd1);
        check_output("rd_hold_addr", master_address, prev_rd_addr);
      end
      if (prev_wr_stall) begin
        check_output("wr_hold_strobe", 32'(master2_write), 32'd1);
        check_output("wr_hold_addr", master2_address, prev_wr_addr);
        check_output("wr_hold_data", master2_writedata, prev_wr_data);
      end
      if (master_read && !master_waitrequest) begin
        if (exp_rd.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_read: got addr 0x%08h, expected no read", master_address);
        end else begin
          check_output("rd_addr", master_address, exp_rd.pop_front());
        end
        job_rd++;
        check_output("inflight_le_depth", 32'((job_rd - job_wr) <= DEPTH), 32'd1);
      end
      if (master2_write && !master2_waitrequest) begin
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: got addr 0x%08h, expected no write", master2_address);
        end else begin
          e = exp_wr.pop_front();
          check_output("wr_addr", master2_address, e.addr);
          check_output("wr_data", master2_writedata, e.data);
        end
        sram_mem[master2_address] = master2_writedata;
        job_wr++;
      end
      prev_rd_stall = master_read && master_waitrequest;
      prev_rd_addr  = master_address;
      prev_wr_stall = master2_write && master2_waitrequest;
      prev_wr_addr  = master2_address;
      prev_wr_data  = master2_writedata;
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(negedge clk);
    slave_write     = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int stalls,
                          output logic timed_out, input int budget);
    @(negedge clk);
    slave_address = a;
    slave_read    = 1'b1;
    stalls        = 0;
    timed_out     = 1'b0;
    #1;
    while (slave_waitrequest && !timed_out) begin
      @(negedge clk);
      #1;
      stalls++;
      if (stalls >= budget) timed_out = 1'b1;
    end
    d = slave_readdata;
    @(negedge clk);
    slave_read = 1'b0;
  endtask

  // Reference model: a job is N reads at src+4i and N writes of the
  // (optionally clamped) word to dst+4i, all modulo 2^32.
  task automatic program_job(input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] n, input logic relu);
    wr_t         e;
    logic [31:0] a;
    logic [31:0] w;
    cpu_write(OFF_SRC, src);
    cpu_write(OFF_DST, dst);
    cpu_write(OFF_COUNT, n);
    cpu_write(OFF_CTRL, {31'd0, relu});
    job_rd = 0;
    job_wr = 0;
    for (int i = 0; i < int'(n); i++) begin
      a = src + 32'(i) * 32'd4;
      w = sdram_read(a);
      exp_rd.push_back(a);
      e.addr = dst + 32'(i) * 32'd4;
      e.data = (relu && w[31]) ? 32'd0 : w;
      exp_wr.push_back(e);
    end
  endtask

  task automatic wait_done(input logic expect_stall);
    logic [31:0] d;
    int          stalls;
    logic        to;
    cpu_read(OFF_START, d, stalls, to, 5000);
    check_output("done_timeout", 32'(to), 32'd0);
    check_output("start_readdata", d, 32'd0);
    check_output("start_stalled", 32'(stalls > 0), 32'(expect_stall));
    check_output("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check_output("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic apply_stimulus(input logic [31:0] src, input logic [31:0] dst,
                                input logic [31:0] n, input logic relu);
    program_job(src, dst, n, relu);
    cpu_write(OFF_START, 32'd1);
    wait_done(n != 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          stalls;
    logic        to;
    int          snap;
    int          budget;

    $display("[TB] act_dma bench start");

    // Reset state
    #1;
    check_output("rst_master_read", 32'(master_read), 32'd0);
    check_output("rst_master2_write", 32'(master2_write), 32'd0);
    check_output("rst_master_addr", master_address, 32'd0);
    check_output("rst_master2_addr", master2_address, 32'd0);
    check_output("rst_master2_wdata", master2_writedata, 32'd0);
    check_output("rst_waitreq", 32'(slave_waitrequest), 32'd0);
    check_output("rst_readdata", slave_readdata, 32'd0);
    check_output("tied_outputs", {master_writedata[30:0], master_write, master2_read}, 33'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      cpu_read(4'(r), d, stalls, to, 10);
      check_output($sformatf("rst_reg%0d", r), d, 32'd0);
    end

    // Register access
    cpu_write(OFF_CTRL, 32'hFFFF_FFFF);
    cpu_read(OFF_CTRL, d, stalls, to, 10);
    check_output("ctrl_bit0_only", d, 32'd1);
    cpu_write(OFF_DST, 32'h1234_5678);
    cpu_read(OFF_DST, d, stalls, to, 10);
    check_output("dst_readback", d, 32'h1234_5678);
    cpu_write(4'd9, 32'hDEAD_BEEF);
    cpu_read(4'd9, d, stalls, to, 10);
    check_output("unmapped_reads_zero", d, 32'd0);

    // Test 1: plain copy, fixed latency 3, no stalls
    stall_pct = 0; lat_min = 3; lat_max = 3;
    apply_stimulus(32'h100, 32'h0, 32'd4, 1'b0);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("t1_sram%0d", i), sram_mem[32'(i * 4)], sdram_read(32'h100 + 32'(i * 4)));

    // Test 2: ReLU clamping of negative Q16.16 words
    sdram_mem[32'h200] = 32'hFFFF_0000;
    sdram_mem[32'h204] = 32'h0001_8000;
    sdram_mem[32'h208] = 32'h8000_0000;
    sdram_mem[32'h20C] = 32'h0000_0000;
    apply_stimulus(32'h200, 32'h800, 32'd4, 1'b1);
    check_output("t2_sram0", sram_mem[32'h800], 32'h0);
    check_output("t2_sram1", sram_mem[32'h804], 32'h0001_8000);
    check_output("t2_sram2", sram_mem[32'h808], 32'h0);
    check_output("t2_sram3", sram_mem[32'h80C], 32'h0);

    // Test 3: random stalls and latency, random addresses and relu
    stall_pct = 35; lat_min = 1; lat_max = 6;
    for (int k = 0; k < 3; k++)
      apply_stimulus($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 32'd32, 1'($urandom_range(1)));

    // Test 4: N=0 does nothing; start while busy is ignored
    stall_pct = 0; lat_min = 2; lat_max = 2;
    program_job(32'h300, 32'h900, 32'd0, 1'b0);
    snap = strobe_cycles;
    cpu_write(OFF_START, 32'd1);
    repeat (10) @(negedge clk);
    check_output("n0_no_strobes", 32'(strobe_cycles - snap), 32'd0);
    cpu_read(OFF_START, d, stalls, to, 10);
    check_output("n0_no_stall", 32'(stalls), 32'd0);
    check_output("n0_readdata", d, 32'd0);

    stall_pct = 40; lat_min = 1; lat_max = 6;
    program_job(32'h400, 32'hA00, 32'd16, 1'b0);
    cpu_write(OFF_START, 32'd1);
    cpu_write(OFF_SRC, 32'h7000);
    cpu_write(OFF_COUNT, 32'd5);
    cpu_write(OFF_START, 32'd1);
    cpu_read(OFF_SRC, d, stalls, to, 10);
    check_output("busy_reg_readback", d, 32'h7000);
    check_output("busy_reg_no_stall", 32'(stalls), 32'd0);
    wait_done(1'b1);
    snap = strobe_cycles;
    repeat (20) @(negedge clk);
    check_output("busy_start_ignored", 32'(strobe_cycles - snap), 32'd0);

    // Test 5: reset in the middle of a job, then a fresh job
    stall_pct = 20;
    program_job(32'h500, 32'hB00, 32'd16, 1'b0);
    cpu_write(OFF_START, 32'd1);
    budget = 0;
    while (job_wr < 5 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check_output("midjob_reach_timeout", 32'(budget >= 2000), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_master_read", 32'(master_read), 32'd0);
    check_output("midrst_master2_write", 32'(master2_write), 32'd0);
    check_output("midrst_master2_wdata", master2_writedata, 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    cpu_read(OFF_COUNT, d, stalls, to, 10);
    check_output("midrst_count_cleared", d, 32'd0);
    apply_stimulus(32'h600, 32'hC00, 32'd3, 1'b0);

    // Test 6: source address wraps past 2^32
    stall_pct = 0; lat_min = 1; lat_max = 3;
    apply_stimulus(32'hFFFF_FFF8, 32'h4000, 32'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against an unforeseen hang anywhere in the run.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
